md_unit_ctrl: RTL and testbench



---
 rtl/md_unit_ctrl_if.sv | 14 +
 rtl/md_unit_ctrl.sv | 81 ++++++++
 tb/tb_md_unit_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/md_unit_ctrl_if.sv
// md_unit_ctrl_if: issue and result bundle between the E stage and the multiply/divide controller
interface md_unit_ctrl_if;
  logic [31:0] D1;
  logic [31:0] D2;
  logic [2:0]  MDOp;
  logic        Start;
  logic        IsMD_D;
  logic        Busy;
  logic        Stall;
  logic [31:0] HI;
  logic [31:0] LO;
  modport master (output D1, D2, MDOp, Start, IsMD_D, input Busy, Stall, HI, LO);
  modport slave  (input D1, D2, MDOp, Start, IsMD_D, output Busy, Stall, HI, LO);
endinterface

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multi-cycle multiply/divide sequencer owning HI/LO, with D-stage stall request
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic            clk,
  input logic            reset,
  md_unit_ctrl_if.slave  bus
);
  localparam logic [3:0] MC = 4'(MULT_CYCLES);
  localparam logic [3:0] DC = 4'(DIV_CYCLES);
  localparam logic [2:0] OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3,
                         OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic        busy, accept, done;
  logic signed [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag, b_mag, b_den, uq, ur, sq, sr, udq, udr;
  assign busy   = cnt_q != 4'd0;
  assign accept = bus.Start & ~busy;
  assign done   = cnt_q == 4'd1;
  assign prod_s = $signed(a_q) * $signed(b_q);
  assign prod_u = {32'b0, a_q} * {32'b0, b_q};
  // Signed divide on magnitudes; 0x80000000 / -1 then wraps to 0x80000000 rem 0 naturally
  assign a_mag = a_q[31] ? -a_q : a_q;
  assign b_mag = b_q[31] ? -b_q : b_q;
  assign b_den = (b_q == 32'd0) ? 32'd1 : b_q;
  assign uq    = a_mag / ((b_mag == 32'd0) ? 32'd1 : b_mag);
  assign ur    = a_mag % ((b_mag == 32'd0) ? 32'd1 : b_mag);
  assign sq    = (a_q[31] ^ b_q[31]) ? -uq : uq;
  assign sr    = a_q[31] ? -ur : ur;
  assign udq   = a_q / b_den;
  assign udr   = a_q % b_den;
  always_comb begin
    cnt_d = busy ? cnt_q - 4'd1 : cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (accept) begin
      if (bus.MDOp >= OP_MULT && bus.MDOp <= OP_DIVU) begin
        op_d  = bus.MDOp;
        a_d   = bus.D1;
        b_d   = bus.D2;
        cnt_d = (bus.MDOp <= OP_MULTU) ? MC : DC;
      end
      hi_d = (bus.MDOp == OP_MTHI) ? bus.D1 : hi_d;
      lo_d = (bus.MDOp == OP_MTLO) ? bus.D1 : lo_d;
    end
    if (done) begin
      if (op_q == OP_MULT) {hi_d, lo_d} = prod_s;
      else if (op_q == OP_MULTU) {hi_d, lo_d} = prod_u;
      else if (op_q == OP_DIV && b_q != 32'd0) {hi_d, lo_d} = {sr, sq};
      else if (op_q == OP_DIVU && b_q != 32'd0) {hi_d, lo_d} = {udr, udq};
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end
  assign bus.Busy  = busy;
  assign bus.Stall = bus.IsMD_D & (busy | bus.Start);
  assign bus.HI    = hi_q;
  assign bus.LO    = lo_q;
endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl: directed checks of busy timing, stall, HI/LO results and reset abort
module tb_md_unit_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  md_unit_ctrl_if bus();
  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [2:0] op, input logic [31:0] d1, input logic [31:0] d2);
    bus.Start = 1'b1;
    bus.MDOp = op;
    bus.D1 = d1;
    bus.D2 = d2;
    #1;
    chk("stall_issue", {31'b0, bus.Stall}, {31'b0, bus.IsMD_D});
    tick();
    bus.Start = 1'b0;
    bus.MDOp = 3'd0;
    bus.D1 = $urandom;
    bus.D2 = $urandom;
    #1;
  endtask
  task automatic wait_busy(input int n);
    for (int i = 0; i < n; i++) begin
      chk("busy_hi", {31'b0, bus.Busy}, 32'd1);
      chk("stall_busy", {31'b0, bus.Stall}, {31'b0, bus.IsMD_D});
      tick();
    end
    chk("busy_lo", {31'b0, bus.Busy}, 32'd0);
    chk("stall_idle", {31'b0, bus.Stall}, 32'd0);
  endtask
  initial begin
    bus.D1 = '0;
    bus.D2 = '0;
    bus.MDOp = '0;
    bus.Start = 1'b0;
    bus.IsMD_D = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", {31'b0, bus.Busy}, 32'd0);
    chk("rst_hi", bus.HI, 32'd0);
    chk("rst_lo", bus.LO, 32'd0);
    bus.IsMD_D = 1'b1;
    #1;
    chk("stall_nostart", {31'b0, bus.Stall}, 32'd0);
    issue(3'd1, 32'hFFFFFFFE, 32'd3);
    wait_busy(5);
    chk("mult_hi", bus.HI, 32'hFFFFFFFF);
    chk("mult_lo", bus.LO, 32'hFFFFFFFA);
    bus.IsMD_D = 1'b0;
    issue(3'd2, 32'hFFFFFFFF, 32'd2);
    wait_busy(5);
    chk("multu_hi", bus.HI, 32'h00000001);
    chk("multu_lo", bus.LO, 32'hFFFFFFFE);
    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    wait_busy(10);
    chk("div_hi", bus.HI, 32'hFFFFFFFF);
    chk("div_lo", bus.LO, 32'hFFFFFFFD);
    issue(3'd5, 32'h11, 32'd0);
    chk("mthi_busy", {31'b0, bus.Busy}, 32'd0);
    chk("mthi_hi", bus.HI, 32'h11);
    issue(3'd6, 32'h22, 32'd0);
    chk("mtlo_lo", bus.LO, 32'h22);
    chk("mtlo_hi", bus.HI, 32'h11);
    issue(3'd4, 32'd5, 32'd0);
    wait_busy(10);
    chk("div0_hi", bus.HI, 32'h11);
    chk("div0_lo", bus.LO, 32'h22);
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_busy(10);
    chk("divov_hi", bus.HI, 32'd0);
    chk("divov_lo", bus.LO, 32'h80000000);
    issue(3'd7, 32'h55, 32'h66);
    chk("nop_busy", {31'b0, bus.Busy}, 32'd0);
    chk("nop_lo", bus.LO, 32'h80000000);
    bus.IsMD_D = 1'b1;
    issue(3'd1, 32'd3, 32'd4);
    chk("ign_busy1", {31'b0, bus.Busy}, 32'd1);
    tick();
    bus.Start = 1'b1;
    bus.MDOp = 3'd2;
    bus.D1 = 32'd100;
    bus.D2 = 32'd100;
    tick();
    bus.Start = 1'b0;
    bus.MDOp = 3'd0;
    wait_busy(3);
    chk("ign_hi", bus.HI, 32'd0);
    chk("ign_lo", bus.LO, 32'd12);
    issue(3'd2, 32'd7, 32'd6);
    wait_busy(5);
    chk("b2b_lo", bus.LO, 32'd42);
    bus.IsMD_D = 1'b0;
    issue(3'd3, 32'd100, 32'd7);
    chk("abort_busy1", {31'b0, bus.Busy}, 32'd1);
    tick();
    chk("abort_busy2", {31'b0, bus.Busy}, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'b0, bus.Busy}, 32'd0);
    chk("abort_hi", bus.HI, 32'd0);
    chk("abort_lo", bus.LO, 32'd0);
    repeat (12) tick();
    chk("abort_late_hi", bus.HI, 32'd0);
    chk("abort_late_lo", bus.LO, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
